// File: rtl/cfg_param_pkg.sv
// cfg_param_pkg: shared FSM states, register indices and beat-counter type for cfg_param_sequencer
package cfg_param_pkg;
  typedef enum logic [1:0] {INIT, IDLE, CALC, PUSH} state_t;
  typedef logic [1:0] beat_cnt_t;
  localparam beat_cnt_t IDX_WIDTH = 2'd0;
  localparam beat_cnt_t IDX_DEPTH = 2'd1;
  localparam beat_cnt_t IDX_ARR   = 2'd2;
  localparam beat_cnt_t IDX_OFF   = 2'd3;
endpackage

// File: rtl/cfg_param_sequencer_if.sv
// cfg_param_sequencer_if: host write channel plus downstream config beat channel
// master: host/consumer side (drives wr_valid/wr_addr/wr_data/cfg_ready)
// slave:  sequencer side (drives wr_ready/wr_err/cfg_valid/cfg_addr/cfg_data/init_done)
interface cfg_param_sequencer_if #(
  parameter int DW = 32
);
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          init_done;
  modport master (
    output wr_valid, wr_addr, wr_data, cfg_ready,
    input  wr_ready, wr_err, cfg_valid, cfg_addr, cfg_data, init_done
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, cfg_ready,
    output wr_ready, wr_err, cfg_valid, cfg_addr, cfg_data, init_done
  );
endinterface

// File: rtl/cfg_param_derive.sv
// cfg_param_derive: registered derivation arr_q = width*depth, off_q = arr_q-1 (mod 2^DW)
// Ports: clk, rst (sync, active-high), width/depth in; arr_q/off_q out, one-cycle latency
module cfg_param_derive #(
  parameter int WIDTH_DEF = 8,
  parameter int DEPTH_DEF = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] width,
  input  logic [DW-1:0] depth,
  output logic [DW-1:0] arr_q,
  output logic [DW-1:0] off_q
);
  logic [DW-1:0] arr_d, off_d;
  always_comb begin
    arr_d = width * depth;
    off_d = arr_d - DW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_q <= DW'(WIDTH_DEF * DEPTH_DEF);
      off_q <= DW'(WIDTH_DEF * DEPTH_DEF) - DW'(1);
    end else begin
      arr_q <= arr_d;
      off_q <= off_d;
    end
  end
endmodule

// File: rtl/cfg_param_sequencer.sv
// cfg_param_sequencer: broadcasts default config after reset, then pushes host-updated and derived registers
// Ports: clk, rst (sync, active-high); bus (cfg_param_sequencer_if.slave) carries the host write
// channel (wr_*) and the downstream valid/ready beat channel (cfg_*) plus init_done.
// Optional: define CFG_PARAM_SEQ_FILTER_EN to swallow writes that do not change the register.
module cfg_param_sequencer
  import cfg_param_pkg::*;
#(
  parameter int WIDTH_DEF = 8,
  parameter int DEPTH_DEF = 16,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  cfg_param_sequencer_if.slave bus
);
  state_t        state_q, state_d;
  logic [DW-1:0] width_q, width_d, depth_q, depth_d, cfg_data_q, cfg_data_d, arr, off;
  beat_cnt_t     cfg_addr_q, cfg_addr_d, idx_q, idx_d, nxt;
  logic          cfg_valid_q, cfg_valid_d, wr_err_q, wr_err_d, init_done_q, init_done_d;
  logic          done, same;
  logic [DW-1:0] regs [4];

  cfg_param_derive #(
    .WIDTH_DEF(WIDTH_DEF),
    .DEPTH_DEF(DEPTH_DEF),
    .DW(DW)
  ) u_derive (
    .clk(clk),
    .rst(rst),
    .width(width_q),
    .depth(depth_q),
    .arr_q(arr),
    .off_q(off)
  );

  assign regs[IDX_WIDTH] = width_q;
  assign regs[IDX_DEPTH] = depth_q;
  assign regs[IDX_ARR]   = arr;
  assign regs[IDX_OFF]   = off;
  assign done = cfg_valid_q && bus.cfg_ready;
  // INIT walks 0..3; PUSH jumps from the written primary index straight to ARR, then OFF
  assign nxt = (state_q == PUSH && !cfg_addr_q[1]) ? IDX_ARR : cfg_addr_q + 2'd1;
`ifdef CFG_PARAM_SEQ_FILTER_EN
  assign same = bus.wr_data == (bus.wr_addr[0] ? depth_q : width_q);
`else
  assign same = 1'b0;
`endif

  assign bus.wr_ready  = state_q == IDLE;
  assign bus.wr_err    = wr_err_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    depth_d     = depth_q;
    idx_d       = idx_q;
    cfg_valid_d = cfg_valid_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    init_done_d = init_done_q;
    wr_err_d    = 1'b0;
    case (state_q)
      INIT, PUSH: begin
        if (state_q == INIT && !cfg_valid_q) begin
          cfg_valid_d = 1'b1;
          cfg_addr_d  = IDX_WIDTH;
          cfg_data_d  = regs[IDX_WIDTH];
        end else if (done && cfg_addr_q == IDX_OFF) begin
          cfg_valid_d = 1'b0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else if (done) begin
          cfg_addr_d = nxt;
          cfg_data_d = regs[nxt];
        end
      end
      IDLE: begin
        if (bus.wr_valid && bus.wr_addr[1]) begin
          wr_err_d = 1'b1;
        end else if (bus.wr_valid && !same) begin
          idx_d   = bus.wr_addr;
          width_d = bus.wr_addr[0] ? width_q : bus.wr_data;
          depth_d = bus.wr_addr[0] ? bus.wr_data : depth_q;
          state_d = CALC;
        end
      end
      CALC: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = idx_q;
        cfg_data_d  = regs[idx_q];
        state_d     = PUSH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      width_q     <= DW'(WIDTH_DEF);
      depth_q     <= DW'(DEPTH_DEF);
      idx_q       <= IDX_WIDTH;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= IDX_WIDTH;
      cfg_data_q  <= '0;
      init_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      depth_q     <= depth_d;
      idx_q       <= idx_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      init_done_q <= init_done_d;
      wr_err_q    <= wr_err_d;
    end
  end
endmodule
